// File: rtl/jtcop_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtcop_pkg
//  Brief    : Shared object-table sizes and DMA state encoding for the
//             MXC-06 sprite path (used by the DMA and the draw stage).
//  Revision : 1.0  initial release
// ============================================================================
package jtcop_pkg;

  localparam int OBJ_WORDS = 1024;
  localparam int OBJ_AW    = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/jtcop_obj_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtcop_obj_dma_if
//  Brief    : Object RAM read bus between the DMA (master) and the RAM (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface jtcop_obj_dma_if
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW
);

  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic          ram_ok;

  modport master (
    output ram_cs,
    output ram_addr,
    input  ram_data,
    input  ram_ok
  );

  modport slave (
    input  ram_cs,
    input  ram_addr,
    output ram_data,
    output ram_ok
  );

endinterface
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_dual_ram
//  Brief    : Simple dual-port RAM, write on port A, registered read on port B.
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_dual_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_b <= mem[addr_b];
  end

endmodule
`default_nettype wire

// File: rtl/jtcop_obj_dma.sv
`default_nettype none
// ============================================================================
//  Module   : jtcop_obj_dma
//  Brief    : Copies object RAM into the back half of a double-buffered table
//             and swaps halves at the next vertical-blank start.
//  Revision : 1.0  initial release
// ============================================================================
module jtcop_obj_dma
  import jtcop_pkg::*;
#(
  parameter int WORDS = OBJ_WORDS,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   LVBL,
  input  logic                   dma_trig,
  jtcop_obj_dma_if.master        ram,
  output logic                   dma_busy,
  input  logic [AW-1:0]          tbl_addr,
  output logic [15:0]            tbl_dout
);

  dma_state_t    r_state, w_state_nx;
  logic [AW-1:0] r_addr,  w_addr_nx;
  logic          r_rearm, w_rearm_nx;
  logic          r_swap_pend, w_swap_pend_nx;
  logic          r_bank,  w_bank_nx;
  logic          r_good;
  logic          r_hold;
  logic          r_lvbl_l;

  logic          w_accept;
  logic          w_last;
  logic          w_vb_fall;

  // r_hold drops the request for one cycle after each accepted word so the
  // next address always sees a fresh, registered acknowledge.
  assign ram.ram_cs   = (r_state == ST_COPY) && !r_hold;
  assign ram.ram_addr = r_addr;
  assign dma_busy     = (r_state == ST_COPY) || r_hold;

  assign w_accept  = ram.ram_cs && ram.ram_ok && r_good;
  assign w_last    = &r_addr;
  assign w_vb_fall = r_lvbl_l && !LVBL;

  always_comb begin
    w_state_nx     = r_state;
    w_addr_nx      = r_addr;
    w_rearm_nx     = r_rearm;
    w_swap_pend_nx = r_swap_pend;
    w_bank_nx      = r_bank;
    case (r_state)
      ST_IDLE: begin
        // A new trigger discards any pending swap: the newest copy wins.
        if (dma_trig) begin
          w_state_nx     = ST_COPY;
          w_addr_nx      = '0;
          w_swap_pend_nx = 1'b0;
          w_rearm_nx     = 1'b0;
        end else if (w_vb_fall && r_swap_pend) begin
          w_bank_nx      = ~r_bank;
          w_swap_pend_nx = 1'b0;
        end
      end
      ST_COPY: begin
        if (dma_trig) w_rearm_nx = 1'b1;
        if (w_accept) begin
          w_addr_nx = r_addr + 1'b1;
          if (w_last) begin
            if (r_rearm || dma_trig) begin
              w_rearm_nx = 1'b0;
            end else begin
              w_state_nx     = ST_IDLE;
              w_swap_pend_nx = 1'b1;
            end
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rearm     <= 1'b0;
      r_swap_pend <= 1'b0;
      r_bank      <= 1'b0;
      r_good      <= 1'b0;
      r_hold      <= 1'b0;
      r_lvbl_l    <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_addr      <= w_addr_nx;
      r_rearm     <= w_rearm_nx;
      r_swap_pend <= w_swap_pend_nx;
      r_bank      <= w_bank_nx;
      r_good      <= ram.ram_cs && ram.ram_ok && !w_accept;
      r_hold      <= w_accept;
      r_lvbl_l    <= LVBL;
    end
  end

  jtframe_dual_ram #(
    .DW (16),
    .AW (AW + 1)
  ) u_tbl (
    .clk    (clk),
    .we_a   (w_accept),
    .addr_a ({~r_bank, r_addr}),
    .data_a (ram.ram_data),
    .addr_b ({r_bank, tbl_addr}),
    .q_b    (tbl_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_jtcop_obj_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtcop_obj_dma
//  Brief    : Directed self-checking bench for the object-table DMA.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtcop_obj_dma;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        LVBL     = 1'b1;
  logic        dma_trig = 1'b0;
  logic        dma_busy;
  logic [9:0]  tbl_addr = '0;
  logic [15:0] tbl_dout;

  // object RAM model: word[i] = i ^ key; ack mode 0=always, 1=random, 2=never
  logic [15:0] key    = '0;
  logic [1:0]  ok_sel = 2'd0;
  logic        ok_rnd = 1'b1;

  int tests = 0;
  int fails = 0;
  int n;

  jtcop_obj_dma_if #(.AW(10)) ram ();

  assign ram.ram_ok   = ram.ram_cs && ((ok_sel == 2'd0) ? 1'b1 :
                                       (ok_sel == 2'd1) ? ok_rnd : 1'b0);
  assign ram.ram_data = {6'd0, ram.ram_addr} ^ key;

  jtcop_obj_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .LVBL     (LVBL),
    .dma_trig (dma_trig),
    .ram      (ram),
    .dma_busy (dma_busy),
    .tbl_addr (tbl_addr),
    .tbl_dout (tbl_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ok_rnd = 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int cnt);
    cnt = 0;
    while (dma_busy && cnt < limit) begin
      tick();
      cnt++;
    end
    check({tag, "_idle"}, 32'(dma_busy), 32'd0);
  endtask

  task automatic wait_addr(input string tag, input logic [9:0] a, input int limit);
    int cnt;
    cnt = 0;
    while (ram.ram_addr != a && cnt < limit) begin
      tick();
      cnt++;
    end
    check(tag, 32'(ram.ram_addr), 32'(a));
  endtask

  task automatic lvbl_fall();
    LVBL = 1'b0;
    tick();
    tick();
    LVBL = 1'b1;
    tick();
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [15:0] exp);
    tbl_addr = a;
    tick();
    check(tag, 32'(tbl_dout), 32'(exp));
  endtask

  task automatic sweep(input string tag, input logic [15:0] k);
    for (int i = 0; i < 1024; i++) rd(tag, 10'(i), 16'(i) ^ k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick();
    tick();
    check("rst_cs",   32'(ram.ram_cs),   32'd0);
    check("rst_busy", 32'(dma_busy),     32'd0);
    check("rst_addr", 32'(ram.ram_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // full copy with an always-ready RAM
    key = 16'hA5A5;
    pulse_trig();
    check("start_cs",   32'(ram.ram_cs),   32'd1);
    check("start_busy", 32'(dma_busy),     32'd1);
    check("start_addr", 32'(ram.ram_addr), 32'd0);
    wait_idle("copy1", 5000, n);
    check("copy1_len_ge_3072", 32'(n >= 3072), 32'd1);
    lvbl_fall();
    sweep("tbl_a5a5", 16'hA5A5);

    // stalled then randomly acknowledged copy
    key    = 16'h3C00;
    ok_sel = 2'd2;
    pulse_trig();
    repeat (6) tick();
    check("stall_cs",   32'(ram.ram_cs),   32'd1);
    check("stall_addr", 32'(ram.ram_addr), 32'd0);
    ok_sel = 2'd1;
    wait_idle("copy2", 40000, n);
    ok_sel = 2'd0;
    rd("dbuf_before_swap", 10'd5, 16'd5 ^ 16'hA5A5);
    lvbl_fall();
    sweep("tbl_3c00", 16'h3C00);

    // retrigger at word 500: full second pass, swap only after it
    key = 16'h1111;
    pulse_trig();
    wait_addr("rearm_at_500", 10'd500, 5000);
    key = 16'h2222;
    pulse_trig();
    wait_addr("pass1_end", 10'd1023, 5000);
    wait_addr("pass2_start", 10'd0, 100);
    check("pass2_busy", 32'(dma_busy), 32'd1);
    lvbl_fall();
    rd("vb_during_copy", 10'd7, 16'd7 ^ 16'h3C00);
    wait_idle("copy3", 5000, n);
    rd("no_swap_before_vb", 10'd7, 16'd7 ^ 16'h3C00);
    lvbl_fall();
    rd("rearm_w0",    10'd0,    16'd0    ^ 16'h2222);
    rd("rearm_w499",  10'd499,  16'd499  ^ 16'h2222);
    rd("rearm_w500",  10'd500,  16'd500  ^ 16'h2222);
    rd("rearm_w1023", 10'd1023, 16'd1023 ^ 16'h2222);

    // completed copy superseded by a trigger on the same cycle as the VB edge
    key = 16'h4444;
    pulse_trig();
    wait_idle("copy4", 5000, n);
    key      = 16'h5555;
    LVBL     = 1'b0;
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    LVBL     = 1'b1;
    rd("trig_beats_swap", 10'd9, 16'd9 ^ 16'h2222);
    lvbl_fall();
    rd("pend_cancelled", 10'd9, 16'd9 ^ 16'h2222);
    wait_idle("copy5", 5000, n);
    lvbl_fall();
    rd("newest_w9",    10'd9,    16'd9    ^ 16'h5555);
    rd("newest_w1023", 10'd1023, 16'd1023 ^ 16'h5555);

    // move the front half to bank 1
    key = 16'h7777;
    pulse_trig();
    wait_idle("copy6", 5000, n);
    lvbl_fall();
    rd("bank1_w3", 10'd3, 16'd3 ^ 16'h7777);

    // reset mid-copy: back to bank 0, which holds the partial copy
    key = 16'h6666;
    pulse_trig();
    wait_addr("reach_300", 10'd300, 5000);
    rst_n = 1'b0;
    #1;
    check("midrst_cs",   32'(ram.ram_cs), 32'd0);
    check("midrst_busy", 32'(dma_busy),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd("midrst_bank0_w10",  10'd10,  16'd10  ^ 16'h6666);
    rd("midrst_bank0_w800", 10'd800, 16'd800 ^ 16'h5555);

    // normal copy after the reset
    key = 16'h0F0F;
    pulse_trig();
    check("post_rst_busy", 32'(dma_busy), 32'd1);
    wait_idle("copy7", 5000, n);
    check("copy7_len_ge_3072", 32'(n >= 3072), 32'd1);
    lvbl_fall();
    rd("post_rst_w0",    10'd0,    16'd0    ^ 16'h0F0F);
    rd("post_rst_w300",  10'd300,  16'd300  ^ 16'h0F0F);
    rd("post_rst_w1023", 10'd1023, 16'd1023 ^ 16'h0F0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
